// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch
//   Receive side of the 4-channel TDM link. A single-bit stream carries
//   channels 0..3 in rotating slots, with frame_sync marking slot 0. Over
//   WIDTH frames the block rebuilds one WIDTH-bit word per channel, MSB first,
//   and presents all four words together with a one-cycle out_valid strobe.
//   The block hunts for frame_sync, then tracks it. A framing error gives a
//   one-cycle sync_err strobe.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   din               serial data bit
//   din_valid         qualifies din/frame_sync (a "beat"); low = stall
//   frame_sync        high on the slot-0 beat of each frame
//   dout0..dout3      assembled channel words, held until next out_valid
//   out_valid         one-cycle strobe, dout0..3 updated this cycle
//   sync_err          one-cycle strobe on early or missing frame sync
//   locked            high while tracking frame sync
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             out_valid,
    output logic             sync_err,
    output logic             locked
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {HUNT, LOCK} state_t;

    state_t                    state;
    logic [1:0]                slot_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [3:0][WIDTH-1:0]     ch_sr;
    logic [WIDTH-1:0]          shifted;

    // Current slot's shift register with the incoming bit appended (MSB first).
    assign shifted = {ch_sr[slot_cnt][WIDTH-2:0], din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot_cnt  <= '0;
            bit_cnt   <= '0;
            ch_sr     <= '0;
            dout0     <= '0;
            dout1     <= '0;
            dout2     <= '0;
            dout3     <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (din_valid) begin
                if (state == HUNT) begin
                    if (frame_sync) begin
                        // Shift registers are already clear in HUNT. This loads slot 0, bit 0.
                        ch_sr       <= '0;
                        ch_sr[0][0] <= din;
                        slot_cnt    <= 2'd1;
                        bit_cnt     <= '0;
                        state       <= LOCK;
                        locked      <= 1'b1;
                    end
                end else begin
                    if (slot_cnt != 2'd0 && frame_sync) begin
                        // Early sync: resynchronise on this beat as slot 0, bit 0.
                        sync_err    <= 1'b1;
                        ch_sr       <= '0;
                        ch_sr[0][0] <= din;
                        slot_cnt    <= 2'd1;
                        bit_cnt     <= '0;
                    end else if (slot_cnt == 2'd0 && !frame_sync) begin
                        // Missing sync: lose lock and throw away the partial words.
                        sync_err <= 1'b1;
                        state    <= HUNT;
                        locked   <= 1'b0;
                        ch_sr    <= '0;
                        slot_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        ch_sr[slot_cnt] <= shifted;
                        slot_cnt        <= slot_cnt + 2'd1;
                        if (slot_cnt == 2'd3) begin
                            if (bit_cnt == BW'(WIDTH - 1)) begin
                                // Last bit of channel 3: every word is complete.
                                dout0     <= ch_sr[0];
                                dout1     <= ch_sr[1];
                                dout2     <= ch_sr[2];
                                dout3     <= shifted;
                                out_valid <= 1'b1;
                                bit_cnt   <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Testbench for tdm_demux_4ch (WIDTH=8). It uses table-driven word sets and
// hand-written framing corner cases, then randomized traffic. Every cycle is
// checked against a beat-position reference model.
module tb_tdm_demux_4ch;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         din, din_valid, frame_sync;
    logic [W-1:0] dout0, dout1, dout2, dout3;
    logic         out_valid, sync_err, locked;

    always #5 clk = ~clk;

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .dout0(dout0), .dout1(dout1),
        .dout2(dout2), .dout3(dout3), .out_valid(out_valid),
        .sync_err(sync_err), .locked(locked)
    );

    int n_tests = 0, n_fail = 0;
    int ov_cnt, se_cnt, cyc;

    // Reference model: position within the 4*W-beat word set.
    // Beat p carries bit (W-1 - p/4) of channel p%4.
    logic         m_locked;
    int           m_pos;
    logic [W-1:0] m_w [4];
    logic [W-1:0] m_dout [4];
    logic         m_ov, m_se;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_pos = 0; m_ov = 1'b0; m_se = 1'b0;
        for (int i = 0; i < 4; i++) begin m_w[i] = '0; m_dout[i] = '0; end
    endtask

    task automatic model_clear_words();
        for (int i = 0; i < 4; i++) m_w[i] = '0;
    endtask

    task automatic model_put(logic d);
        m_w[m_pos % 4][W - 1 - m_pos / 4] = d;
    endtask

    task automatic model_step(logic v, logic d, logic fs);
        m_ov = 1'b0; m_se = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1; m_pos = 0; model_clear_words();
                model_put(d); m_pos = 1;
            end
        end else if (fs && (m_pos % 4) != 0) begin
            m_se = 1'b1; m_pos = 0; model_clear_words();
            model_put(d); m_pos = 1;
        end else if (!fs && (m_pos % 4) == 0) begin
            m_se = 1'b1; m_locked = 1'b0; m_pos = 0; model_clear_words();
        end else begin
            model_put(d);
            m_pos++;
            if (m_pos == 4 * W) begin
                for (int i = 0; i < 4; i++) m_dout[i] = m_w[i];
                m_ov = 1'b1; m_pos = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("locked",    locked,    m_locked);
        chk("out_valid", out_valid, m_ov);
        chk("sync_err",  sync_err,  m_se);
        chk("dout0", dout0, m_dout[0]);
        chk("dout1", dout1, m_dout[1]);
        chk("dout2", dout2, m_dout[2]);
        chk("dout3", dout3, m_dout[3]);
    endtask

    // One clock cycle: drive, let the edge happen, check on the falling edge.
    task automatic beat(logic v, logic d, logic fs);
        din_valid = v; din = d; frame_sync = fs;
        @(posedge clk);
        model_step(v, d, fs);
        @(negedge clk);
        cyc++;
        check_all();
        if (out_valid) ov_cnt++;
        if (sync_err)  se_cnt++;
    endtask

    // Send beats first..last of a word set. frame_sync is on every slot-0 beat.
    task automatic send_beats(logic [3:0][W-1:0] wds, int first, int last,
                              int stall_at, int stall_len);
        for (int i = first; i <= last; i++) begin
            beat(1'b1, wds[i % 4][W - 1 - i / 4], (i % 4) == 0);
            if (i == stall_at)
                repeat (stall_len) beat(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic chk_words(string nm, logic [3:0][W-1:0] wds);
        chk({nm, "_d0"}, dout0, wds[0]);
        chk({nm, "_d1"}, dout1, wds[1]);
        chk({nm, "_d2"}, dout2, wds[2]);
        chk({nm, "_d3"}, dout3, wds[3]);
    endtask

    typedef struct {
        logic [3:0][W-1:0] w;
        int                stall_at;
        int                stall_len;
    } vec_t;

    vec_t tbl [4];
    logic [3:0][W-1:0] wa, wb, wc, wd;

    initial begin
        tbl[0] = '{w: {8'h01, 8'hFF, 8'h3C, 8'hA5}, stall_at: -1, stall_len: 0};
        tbl[1] = '{w: {8'h01, 8'hFF, 8'h3C, 8'hA5}, stall_at: 13, stall_len: 3};
        tbl[2] = '{w: {8'h80, 8'h00, 8'h7E, 8'h5A}, stall_at: 2,  stall_len: 5};
        tbl[3] = '{w: {8'hC3, 8'h96, 8'h69, 8'hF0}, stall_at: 30, stall_len: 1};
        wa = {8'h01, 8'hFF, 8'h3C, 8'hA5};
        wb = {8'h78, 8'h56, 8'h34, 8'h12};
        wc = {8'hF0, 8'h0F, 8'h5A, 8'hC3};
        wd = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held while inputs are toggled.
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            din = 1'($urandom); din_valid = 1'($urandom); frame_sync = 1'($urandom);
            @(negedge clk);
            chk("rst_outs", {dout0, dout1, dout2, dout3}, '0);
            chk("rst_ov",   out_valid, 1'b0);
            chk("rst_se",   sync_err,  1'b0);
            chk("rst_lock", locked,    1'b0);
        end
        rst_n = 1'b1;
        cyc = 0;
        repeat (3) beat(1'b1, 1'($urandom), 1'b0);
        chk("locked_pre_sync", locked, 1'b0);

        // Word sets from the table, with optional stalls.
        foreach (tbl[k]) begin
            ov_cnt = 0; se_cnt = 0; cyc = 0;
            send_beats(tbl[k].w, 0, 4 * W - 1, tbl[k].stall_at, tbl[k].stall_len);
            chk("set_ov_now",  out_valid, 1'b1);
            chk("set_latency", cyc, 4 * W + tbl[k].stall_len);
            chk_words("set", tbl[k].w);
            beat(1'b0, 1'b0, 1'b0);
            chk("ov_width", out_valid, 1'b0);
            chk("ov_count", ov_cnt, 1);
            chk("set_no_err", se_cnt, 0);
            chk("set_locked", locked, 1'b1);
        end

        // Early sync on a slot-2 beat starts a new set.
        send_beats(wa, 0, 9, -1, 0);
        se_cnt = 0; ov_cnt = 0;
        send_beats(wb, 0, 4 * W - 1, -1, 0);
        chk("early_err_cnt", se_cnt, 1);
        chk("early_locked",  locked, 1'b1);
        chk("early_ov_cnt",  ov_cnt, 1);
        chk_words("early", wb);

        // Missing sync drops lock. Later non-sync beats are ignored.
        send_beats(wa, 0, 3, -1, 0);
        beat(1'b1, 1'b1, 1'b0);
        chk("miss_err",  sync_err, 1'b1);
        chk("miss_lock", locked,   1'b0);
        repeat (7) beat(1'b1, 1'($urandom), 1'b0);
        chk("miss_hunt", locked, 1'b0);
        ov_cnt = 0;
        send_beats(wc, 0, 4 * W - 1, -1, 0);
        chk("miss_ov_cnt", ov_cnt, 1);
        chk_words("miss", wc);

        // Asynchronous reset in the middle of a set.
        send_beats(wa, 0, 19, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", {dout0, dout1, dout2, dout3}, '0);
        chk("arst_lock", locked, 1'b0);
        chk("arst_ov",   out_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        send_beats(wd, 0, 4 * W - 1, -1, 0);
        chk("arst_ov_cnt", ov_cnt, 1);
        chk_words("arst", wd);

        // Random traffic: mostly well framed, with occasional sync faults and stalls.
        for (int i = 0; i < 3000; i++) begin
            logic v, fs;
            v  = ($urandom_range(3) != 0);
            fs = m_locked ? ((m_pos % 4) == 0) : ($urandom_range(3) == 0);
            if ($urandom_range(60) == 0) fs = ~fs;
            beat(v, 1'($urandom), fs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
Four-channel time-division demultiplexer; the receive-side counterpart of the team's 4-to-1 mux. Takes a single-bit TDM stream where slots 0..3 carry channels d0..d3 in rotation, with a frame sync marking slot 0. Reassembles one WIDTH-bit word per channel over WIDTH frames and presents all four words in parallel with a one-cycle valid strobe. Includes frame-sync hunting and error detection.

Parameters:
WIDTH, 8, bits per channel word; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  1  TDM serial data bit.
din_valid  input  1  din and frame_sync are sampled only when high.
frame_sync  input  1  high on the beat carrying slot 0 of each frame.
dout0  output  WIDTH  assembled word, channel 0.
dout1  output  WIDTH  assembled word, channel 1.
dout2  output  WIDTH  assembled word, channel 2.
dout3  output  WIDTH  assembled word, channel 3.
out_valid  output  1  one-cycle strobe; dout0..3 updated this cycle.
sync_err  output  1  one-cycle strobe on framing error.
locked  output  1  high while in LOCK state.

Behaviour:
- Reset, async on rst_n low: state=HUNT; slot_cnt=0; bit_cnt=0; all shift registers 0; dout0..3=0; out_valid=0; sync_err=0; locked=0. Reset mid-word discards all partial data.
- Beat: rising clk edge with din_valid=1. Cycles with din_valid=0 change nothing except clearing the strobes; stalls of any length are legal.
- HUNT:
  - Beats with frame_sync=0 are ignored.
  - A beat with frame_sync=1 is slot 0, bit 0: shift din into ch0; set slot_cnt=1, bit_cnt=0; go to LOCK; locked=1 from the next cycle.
- LOCK, per beat:
  - slot_cnt!=0 and frame_sync=1 (early sync):
    - sync_err=1 next cycle.
    - Treat the beat as slot 0, bit 0 of a new word set: clear all four shift registers, load din into ch0, slot_cnt=1, bit_cnt=0.
    - Remain in LOCK.
  - slot_cnt==0 and frame_sync=0 (missing sync):
    - sync_err=1 next cycle.
    - Go to HUNT; locked=0 next cycle.
    - Clear shift registers, slot_cnt and bit_cnt; din is discarded.
  - Otherwise: ch_sr[slot_cnt] <= {ch_sr[slot_cnt][WIDTH-2:0], din} (MSB first); slot_cnt increments mod 4.
    - When slot_cnt wraps 3->0, bit_cnt increments.
    - If slot_cnt==3 and bit_cnt==WIDTH-1:
      - dout0..3 are loaded with the completed words, including this bit.
      - out_valid=1 on the next cycle (latency 1 cycle after the final beat's edge).
      - bit_cnt=0; shift registers are free for the next word.
- dout0..3 hold their value until the next out_valid. They are never updated by errors or partial words.
- out_valid and sync_err are registered single-cycle pulses. They never assert simultaneously.
- Words complete only every 4*WIDTH beats, so back-to-back out_valid pulses are impossible.

Test Plan:
1. Reset: hold rst_n=0, toggle din/din_valid/frame_sync -> dout0..3=0, out_valid=0, sync_err=0, locked=0 throughout; release -> locked=0 until first sync beat.
2. Nominal (WIDTH=8): send 32 continuous beats interleaving 8'hA5, 8'h3C, 8'hFF, 8'h01 MSB-first, frame_sync on beats 0,4,...,28 -> locked=1 after beat 0; one out_valid pulse the cycle after beat 31 with dout0=A5, dout1=3C, dout2=FF, dout3=01; no sync_err.
3. Stall: repeat scenario 2 with din_valid=0 for 3 cycles after beat 13 and 1 cycle after beat 31 -> identical words; out_valid lands 3 cycles later than in scenario 2 and is exactly one cycle wide.
4. Early sync: after 10 good beats assert frame_sync on a slot-2 beat, then send 32 clean beats (words 12,34,56,78) starting with that beat as slot 0 -> sync_err pulse once; locked stays 1; dout unchanged until out_valid with 12,34,56,78.
5. Missing sync: lock, then send a slot-0 beat with frame_sync=0 -> sync_err pulse, locked=0; the next 7 beats (no sync) are ignored; then a sync beat plus 31 good beats -> correct words delivered.
6. Reset mid-operation: assert rst_n=0 after 20 beats of a word set -> outputs clear immediately (async); after release a full 32-beat set yields correct words with no residue from the aborted set.
